spmv_mem_responder: RTL and testbench
=====================================

Name: spmv_mem_responder

Overview:
Synthesizable responder for the PE main-memory port: the memory side of req_mem_*/rsp_mem_*. Backed by on-chip block RAM with a fixed-latency load pipeline and a credit-limited response FIFO. Gives FPGA-in-the-loop and emulation runs a deterministic memory without the Convey MC.

Parameters:
ADDR_WIDTH, 48, byte-address width of req_mem_addr
DEPTH_LOG2, 14, log2 of RAM depth in 64-bit words
LATENCY, 8, cycles from load accept to earliest rsp_mem_push (minimum 2)
MAX_OUTSTANDING, 16, response FIFO depth and credit limit (power of 2)
STALL_SLACK, 4, loads absorbable after req_mem_stall rises

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_mem_ld  in  1  load request
req_mem_st  in  1  store request
req_mem_addr  in  ADDR_WIDTH  byte address
req_mem_d_or_tag  in  64  store data (st) or tag in bits [2:0] (ld)
req_mem_stall  out  1  almost-full back-pressure to PE
rsp_mem_push  out  1  response valid, one cycle per word
rsp_mem_tag  out  3  tag of the returned load
rsp_mem_q  out  64  load data
rsp_mem_stall  in  1  PE response queue almost full; no push while high
outstanding  out  $clog2(MAX_OUTSTANDING)+1  loads accepted but not yet pushed

Behaviour:
- Reset: req_mem_stall=0, rsp_mem_push=0, rsp_mem_tag=0, rsp_mem_q=0, outstanding=0. Delay-line valids and FIFO pointers clear. RAM contents are kept.
- Word index is req_mem_addr[DEPTH_LOG2+2:3]. Bits [2:0] are ignored. Upper bits are ignored, so addresses wrap modulo RAM size.
- Every request is accepted, including while req_mem_stall is high. Stall is advisory almost-full.
- Store: RAM written at the clock edge ending the request cycle. No response.
- Load: RAM read registered, then {tag,data} enters a (LATENCY-1)-stage delay line, then the FIFO.
- Earliest response: request at cycle N gives rsp_mem_push at N+LATENCY when the FIFO is empty and rsp_mem_stall=0.
- Write-first: a load issued at cycle N+1 after a store at N to the same word returns the new data. A load and store issued in the same cycle is illegal. The store wins, the load is dropped, and outstanding is not incremented.
- Output: when FIFO non-empty and rsp_mem_stall=0, pop one entry and drive push/tag/q registered the next cycle. While rsp_mem_stall is high, push=0 and rsp_mem_q/tag=0. Responses stay in load-issue order.
- outstanding: +1 per accepted load, -1 per push, both in the same cycle gives net 0.
- req_mem_stall = (outstanding >= MAX_OUTSTANDING-STALL_SLACK), registered.
- If outstanding would exceed MAX_OUTSTANDING, the load is dropped and the sticky overflow flag is set (simulation $error). A compliant PE never does this.
- Reset mid-operation: all in-flight loads are discarded, and no push occurs from the cycle after rst is sampled high.

Optional Feature:
SPMV_MEM_RSP_STALL_INJECT_EN:
- Defined: a 16-bit LFSR (seed 16'hACE1 on reset, taps 16,14,13,11) gates the FIFO pop. A pop is withheld on any cycle the LFSR low 2 bits are 2'b00, in addition to rsp_mem_stall. Order and data are unchanged; only timing varies.
- Undefined: the LFSR is absent and pops depend on rsp_mem_stall only.

Decomposition:
- Shared package/header spmv_mem_if.vh holds MEM_TAG_WIDTH=3, MEM_DATA_WIDTH=64 and the LFSR seed/taps constants.
- Natural sub-module: spmv_rsp_fifo, a synchronous FIFO with count output, width TAG+DATA, depth MAX_OUTSTANDING.
- Delay line and RAM stay inline.

Test Plan:
1. Store word 0x3FF0000000000000 to addr 0x40, load addr 0x40 tag 5 at cycle 10 -> push at cycle 10+LATENCY=18 with tag 5 and that data.
2. Store addr 0x80 at cycle N, load 0x80 at N+1 -> new data returned (write-first).
3. Issue 12 back-to-back loads (tags 0..7,0..3) -> req_mem_stall high from the cycle after outstanding reaches 12. Responses arrive in order, consecutive cycles, outstanding returns to 0.
4. Hold rsp_mem_stall high for 20 cycles during 8 loads -> no push while high, then 8 pushes in order, none lost.
5. Assert rst with 5 loads in flight -> no push after reset, outstanding=0, RAM data at 0x40 still readable.
6. ld and st together on addr 0x100 -> store performed, no response, outstanding unchanged.

Source files
------------

// File: rtl/spmv_mem_responder_pkg.sv
// Shared constants and types for the SpMV main-memory responder.
// Holds the memory-port tag/data widths, the response entry layout and
// the stall-injection LFSR seed/tap constants.
package spmv_mem_responder_pkg;

  localparam int MEM_TAG_WIDTH  = 3;
  localparam int MEM_DATA_WIDTH = 64;

  // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One returned load: tag in the upper bits, data below
  typedef struct packed {
    logic [MEM_TAG_WIDTH-1:0]  tag;
    logic [MEM_DATA_WIDTH-1:0] q;
  } mem_rsp_t;

endpackage

// File: rtl/spmv_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Head entry is presented combinationally on o_rdata; i_rd advances it.
// DEPTH must be a power of two so the pointers wrap naturally.
module spmv_rsp_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  // Storage array; no reset so it maps onto distributed/block RAM
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + AW'(1);
      if (i_rd) r_rptr <= r_rptr + AW'(1);
      case ({i_wr, i_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/spmv_mem_responder.sv
// Block-RAM backed responder for the PE main-memory port.
// Loads: registered RAM read, (LATENCY-1)-stage delay line including the
// read register, then a response FIFO; an empty FIFO is bypassed so the
// earliest push lands exactly LATENCY cycles after the request.
// Optional macro SPMV_MEM_RSP_STALL_INJECT_EN adds an LFSR that randomly
// withholds pops to vary response timing.
module spmv_mem_responder
  import spmv_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 48,
  parameter int DEPTH_LOG2      = 14,
  parameter int LATENCY         = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int STALL_SLACK     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_mem_ld,
  input  logic                               req_mem_st,
  input  logic [ADDR_WIDTH-1:0]              req_mem_addr,
  input  logic [MEM_DATA_WIDTH-1:0]          req_mem_d_or_tag,
  output logic                               req_mem_stall,
  output logic                               rsp_mem_push,
  output logic [MEM_TAG_WIDTH-1:0]           rsp_mem_tag,
  output logic [MEM_DATA_WIDTH-1:0]          rsp_mem_q,
  input  logic                               rsp_mem_stall,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int DL    = LATENCY - 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(MAX_OUTSTANDING - STALL_SLACK);

  logic [DEPTH_LOG2-1:0]     w_idx;
  logic                      w_ld_req;
  logic                      w_ld_acc;
  logic                      w_ovf;
  logic                      w_pop_ok;
  logic                      w_fifo_empty;
  logic                      w_fifo_rd;
  logic                      w_fifo_wr;
  logic                      w_bypass;
  logic                      w_pop;
  logic [CNT_W-1:0]          w_fifo_cnt;
  mem_rsp_t                  w_fifo_q;
  mem_rsp_t                  w_dl_entry;
  mem_rsp_t                  w_out_entry;
  logic                      w_unused_addr;

  logic [MEM_DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [MEM_DATA_WIDTH-1:0] r_dl_q   [DL];
  logic [MEM_TAG_WIDTH-1:0]  r_dl_tag [DL];
  logic                      r_dl_vld [DL];
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_req_stall;
  logic                      r_push;
  logic [MEM_TAG_WIDTH-1:0]  r_tag;
  logic [MEM_DATA_WIDTH-1:0] r_q;
  logic                      r_overflow;

  // Word index wraps modulo RAM size; byte offset and high bits are ignored
  assign w_idx         = req_mem_addr[DEPTH_LOG2+2:3];
  assign w_unused_addr = ^{req_mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+3], req_mem_addr[2:0]};

  // A simultaneous store wins; the colliding load is dropped
  assign w_ld_req = req_mem_ld & ~req_mem_st;
  assign w_ld_acc = w_ld_req & ((r_cnt != CNT_MAX) | w_pop);
  assign w_ovf    = w_ld_req & ~w_ld_acc;

`ifdef SPMV_MEM_RSP_STALL_INJECT_EN
  logic [15:0] r_lfsr;

  // Free-running LFSR; low bits 00 withhold a pop that cycle
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_pop_ok = ~rsp_mem_stall & (r_lfsr[1:0] != 2'b00);
`else
  assign w_pop_ok = ~rsp_mem_stall;
`endif

  // ---- stage 0: RAM write / registered read, then data delay line ----
  // Store lands at the edge ending its cycle, so a load one cycle later sees it
  always_ff @(posedge clk) begin
    if (req_mem_st) r_mem[w_idx] <= req_mem_d_or_tag;
    r_dl_q[0] <= r_mem[w_idx];
    for (int i = 1; i < DL; i++) r_dl_q[i] <= r_dl_q[i-1];
  end

  // Tags follow the data without reset; only the valids need clearing
  always_ff @(posedge clk) begin
    r_dl_tag[0] <= req_mem_d_or_tag[MEM_TAG_WIDTH-1:0];
    for (int i = 1; i < DL; i++) r_dl_tag[i] <= r_dl_tag[i-1];
  end

  // Valid shift register; reset discards every in-flight load
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DL; i++) r_dl_vld[i] <= 1'b0;
    end else begin
      r_dl_vld[0] <= w_ld_acc;
      for (int i = 1; i < DL; i++) r_dl_vld[i] <= r_dl_vld[i-1];
    end
  end

  // ---- delay-line exit: FIFO write or direct bypass to the output ----
  assign w_dl_entry   = '{tag: r_dl_tag[DL-1], q: r_dl_q[DL-1]};
  assign w_fifo_empty = (w_fifo_cnt == '0);
  assign w_fifo_rd    = w_pop_ok & ~w_fifo_empty;
  assign w_bypass     = w_pop_ok & w_fifo_empty & r_dl_vld[DL-1];
  assign w_fifo_wr    = r_dl_vld[DL-1] & ~w_bypass;
  assign w_pop        = w_fifo_rd | w_bypass;
  assign w_out_entry  = w_fifo_rd ? w_fifo_q : (w_bypass ? w_dl_entry : '0);

  spmv_rsp_fifo #(
    .WIDTH ($bits(mem_rsp_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_fifo_wr),
    .i_wdata (w_dl_entry),
    .i_rd    (w_fifo_rd),
    .o_rdata (w_fifo_q),
    .o_count (w_fifo_cnt)
  );

  // ---- output register: push/tag/q, zeroed whenever nothing is popped ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_push <= 1'b0;
      r_tag  <= '0;
      r_q    <= '0;
    end else begin
      r_push <= w_pop;
      r_tag  <= w_out_entry.tag;
      r_q    <= w_out_entry.q;
    end
  end

  // Outstanding-load counter and registered almost-full stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_req_stall <= 1'b0;
    end else begin
      case ({w_ld_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_req_stall <= (r_cnt >= STALL_TH);
    end
  end

  // Sticky overflow: a load beyond the credit limit was dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf) begin
      r_overflow <= 1'b1;
      if (!r_overflow) $error("spmv_mem_responder: load dropped, outstanding limit exceeded");
    end
  end

  assign req_mem_stall = r_req_stall;
  assign rsp_mem_push  = r_push;
  assign rsp_mem_tag   = r_tag;
  assign rsp_mem_q     = r_q;
  assign outstanding   = r_cnt;

endmodule

// File: tb/tb_spmv_mem_responder.sv
// Directed bench for spmv_mem_responder (default build, no stall injection).
module tb_spmv_mem_responder;

  localparam int AW  = 48;
  localparam int DL2 = 14;
  localparam int LAT = 8;
  localparam int MO  = 16;
  localparam int SS  = 4;
  localparam logic [63:0] BULK_BASE = 64'hA5A5_0000_0000_0000;
  localparam logic [47:0] BULK_ADDR = 48'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_mem_ld = 1'b0;
  logic        req_mem_st = 1'b0;
  logic [47:0] req_mem_addr = '0;
  logic [63:0] req_mem_d_or_tag = '0;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall = 1'b0;
  logic [4:0]  outstanding;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        do_st;
    logic [47:0] st_addr;
    logic [63:0] st_data;
    logic [47:0] ld_addr;
    logic [2:0]  tag;
    logic [63:0] exp_q;
  } vec_t;

  vec_t vecs[6];

  spmv_mem_responder #(
    .ADDR_WIDTH      (AW),
    .DEPTH_LOG2      (DL2),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MO),
    .STALL_SLACK     (SS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_mem_ld       (req_mem_ld),
    .req_mem_st       (req_mem_st),
    .req_mem_addr     (req_mem_addr),
    .req_mem_d_or_tag (req_mem_d_or_tag),
    .req_mem_stall    (req_mem_stall),
    .rsp_mem_push     (rsp_mem_push),
    .rsp_mem_tag      (rsp_mem_tag),
    .rsp_mem_q        (rsp_mem_q),
    .rsp_mem_stall    (rsp_mem_stall),
    .outstanding      (outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic store(input logic [47:0] a, input logic [63:0] d);
    req_mem_st = 1'b1;
    req_mem_addr = a;
    req_mem_d_or_tag = d;
    tick();
    req_mem_st = 1'b0;
  endtask

  // Single load from idle: exact latency, tag, data, counter return to 0
  task automatic load_check(input string nm, input logic [47:0] a, input logic [2:0] t,
                            input logic [63:0] exp);
    int lat = 1;
    req_mem_ld = 1'b1;
    req_mem_addr = a;
    req_mem_d_or_tag = {61'd0, t};
    tick();
    req_mem_ld = 1'b0;
    chk({nm, " outstanding after ld"}, 64'(outstanding), 64'd1);
    while (!rsp_mem_push && lat < LAT + 8) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(LAT));
    chk({nm, " tag"}, 64'(rsp_mem_tag), 64'(t));
    chk({nm, " data"}, rsp_mem_q, exp);
    chk({nm, " outstanding at push"}, 64'(outstanding), 64'd0);
    tick();
    chk({nm, " push one cycle"}, 64'(rsp_mem_push), 64'd0);
  endtask

  // Expect n in-order pushes on consecutive cycles: tag i%8, data BULK_BASE+i
  task automatic collect(input string nm, input int n);
    int waited = 0;
    while (!rsp_mem_push && waited < 40) begin
      tick();
      waited++;
    end
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s push %0d", nm, i), 64'(rsp_mem_push), 64'd1);
      chk($sformatf("%s tag %0d", nm, i), 64'(rsp_mem_tag), 64'(i % 8));
      chk($sformatf("%s data %0d", nm, i), rsp_mem_q, BULK_BASE + 64'(i));
      tick();
    end
    chk({nm, " no extra push"}, 64'(rsp_mem_push), 64'd0);
    chk({nm, " outstanding drained"}, 64'(outstanding), 64'd0);
  endtask

  task automatic issue_loads(input int n, input bit check_stall);
    for (int i = 0; i < n; i++) begin
      req_mem_ld = 1'b1;
      req_mem_addr = BULK_ADDR + 48'(8 * i);
      req_mem_d_or_tag = 64'(i % 8);
      tick();
      if (check_stall && i == 10) chk("stall low at 11", 64'(req_mem_stall), 64'd0);
      if (check_stall && i == 11) begin
        chk("outstanding reaches 12", 64'(outstanding), 64'd12);
        chk("stall low same cycle", 64'(req_mem_stall), 64'd0);
      end
    end
    req_mem_ld = 1'b0;
  endtask

  initial begin
    int npush;

    vecs[0] = '{1'b1, 48'h40,  64'h3FF0_0000_0000_0000, 48'h40,             3'd5, 64'h3FF0_0000_0000_0000};
    vecs[1] = '{1'b1, 48'h80,  64'h0123_4567_89AB_CDEF, 48'h80,             3'd2, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{1'b1, 48'h88,  64'hDEAD_BEEF_CAFE_F00D, 48'h8F,             3'd7, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[3] = '{1'b1, 48'h100, 64'h1111_2222_3333_4444, 48'h2_0100,         3'd0, 64'h1111_2222_3333_4444};
    vecs[4] = '{1'b1, 48'h1_FFF8, 64'h8000_0000_0000_0001, 48'hFFFF_FFFF_FFF8, 3'd3, 64'h8000_0000_0000_0001};
    vecs[5] = '{1'b1, 48'h48,  64'h0,                   48'h40,             3'd1, 64'h3FF0_0000_0000_0000};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("reset req_mem_stall", 64'(req_mem_stall), 64'd0);
    chk("reset push", 64'(rsp_mem_push), 64'd0);
    chk("reset tag", 64'(rsp_mem_tag), 64'd0);
    chk("reset q", rsp_mem_q, 64'd0);
    chk("reset outstanding", 64'(outstanding), 64'd0);
    rst = 1'b0;
    tick();

    // Store/load vectors: latency, write-first, offset/alias wrap, neighbours
    for (int k = 0; k < 6; k++) begin
      if (vecs[k].do_st) store(vecs[k].st_addr, vecs[k].st_data);
      load_check($sformatf("vec%0d", k), vecs[k].ld_addr, vecs[k].tag, vecs[k].exp_q);
      tick();
    end

    // Bulk data for the multi-load sequences
    for (int i = 0; i < 12; i++) store(BULK_ADDR + 48'(8 * i), BULK_BASE + 64'(i));
    tick();

    // 12 loads held in the FIFO: stall threshold, then in-order drain
    rsp_mem_stall = 1'b1;
    issue_loads(12, 1'b1);
    tick();
    chk("stall high cycle after 12", 64'(req_mem_stall), 64'd1);
    chk("no push while held", 64'(rsp_mem_push), 64'd0);
    rsp_mem_stall = 1'b0;
    collect("burst", 12);
    chk("stall cleared after drain", 64'(req_mem_stall), 64'd0);

    // rsp_mem_stall held 20 cycles across 8 loads
    rsp_mem_stall = 1'b1;
    npush = 0;
    for (int i = 0; i < 8; i++) begin
      req_mem_ld = 1'b1;
      req_mem_addr = BULK_ADDR + 48'(8 * i);
      req_mem_d_or_tag = 64'(i);
      tick();
      if (rsp_mem_push) npush++;
    end
    req_mem_ld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_mem_push) npush++;
    end
    chk("pushes while stalled", 64'(npush), 64'd0);
    chk("outstanding while stalled", 64'(outstanding), 64'd8);
    rsp_mem_stall = 1'b0;
    collect("held", 8);

    // Reset with 5 loads in flight
    issue_loads(5, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid-reset push", 64'(rsp_mem_push), 64'd0);
    chk("mid-reset outstanding", 64'(outstanding), 64'd0);
    rst = 1'b0;
    npush = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_mem_push) npush++;
    end
    chk("pushes after reset", 64'(npush), 64'd0);
    chk("outstanding after reset", 64'(outstanding), 64'd0);
    load_check("ram kept", 48'h40, 3'd4, 64'h3FF0_0000_0000_0000);
    tick();

    // Load and store together: store wins, load dropped
    req_mem_ld = 1'b1;
    req_mem_st = 1'b1;
    req_mem_addr = 48'h100;
    req_mem_d_or_tag = 64'h5555_6666_7777_8888;
    tick();
    req_mem_ld = 1'b0;
    req_mem_st = 1'b0;
    chk("ld+st outstanding", 64'(outstanding), 64'd0);
    npush = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_mem_push) npush++;
    end
    chk("ld+st no response", 64'(npush), 64'd0);
    load_check("ld+st stored", 48'h100, 3'd6, 64'h5555_6666_7777_8888);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
